// File: rtl/rc4_pkg.sv
// Shared RC4 datapath definitions: S-memory geometry and the init FSM state type.
package rc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int S_DEPTH  = 1 << S_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE,
    HOLD
  } init_state_t;

endpackage

// File: rtl/init_addr_counter.sv
// Free-running address counter with synchronous clear, enable and an all-ones flag.
module init_addr_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = &count;

endmodule

// File: rtl/init_memory_fsm.sv
// Fills S-memory with the identity permutation, optionally reads it back, then pulses finish.
module init_memory_fsm
  import rc4_pkg::*;
#(
  parameter int ADDR_W = S_ADDR_W,
  parameter int DATA_W = S_DATA_W,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              finish,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q,
  output logic              verify_error
);

  init_state_t       state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] next_count;
  logic [ADDR_W-1:0] prev_count;
  logic              tc;
  logic              cnt_clear;
  logic              cnt_en;
  logic              mismatch;

  assign cnt_clear  = (state == IDLE) && start;
  assign cnt_en     = (state == WRITE) || (state == READ);
  assign next_count = count + 1'b1;
  assign prev_count = count - 1'b1;
  // q lags the presented address by one cycle, so it belongs to count-1.
  assign mismatch   = (q != DATA_W'(prev_count));

  init_addr_counter #(
    .W(ADDR_W)
  ) u_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count),
    .tc     (tc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      finish       <= 1'b0;
      busy         <= 1'b0;
      wren         <= 1'b0;
      address      <= '0;
      data         <= '0;
      verify_error <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= WRITE;
            busy         <= 1'b1;
            wren         <= 1'b1;
            address      <= '0;
            data         <= '0;
            verify_error <= 1'b0;
          end
        end
        WRITE: begin
          if (tc) begin
            wren <= 1'b0;
            if (VERIFY) begin
              state   <= READ;
              address <= '0;
            end else begin
              state  <= DONE;
              finish <= 1'b1;
            end
          end else begin
            address <= next_count;
            data    <= DATA_W'(next_count);
          end
        end
        READ: begin
          if ((count != '0) && mismatch) verify_error <= 1'b1;
          if (tc) state <= DRAIN;
          else    address <= next_count;
        end
        // Counter has wrapped to 0 here, so prev_count is the last address.
        DRAIN: begin
          if (mismatch) verify_error <= 1'b1;
          state  <= DONE;
          finish <= 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= start ? HOLD : IDLE;
        end
        HOLD: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/init_memory_fsm.md
Name: init_memory_fsm

Overview:
- Downstream worker of the top-level controller FSM in the RC4 datapath.
- On a start request from the controller, fills the on-chip S-memory with the identity permutation (S[i] = i for every address).
- Optionally reads every location back and checks it.
- Signals completion to the controller with a one-cycle finish pulse; the controller treats that pulse as its stop input.

Parameters:
- ADDR_W, 8, S-memory address width; the block covers 2**ADDR_W locations.
- DATA_W, 8, S-memory data width; written value = address, truncated or zero-extended to DATA_W.
- VERIFY, 1, 1 = run a read-back check pass after the write pass; 0 = skip it.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  start request from the controller FSM; level or pulse.
- finish  output  1  one-cycle pulse: initialisation (and check, if enabled) complete.
- busy  output  1  high from start acceptance until the cycle finish is asserted, inclusive.
- address  output  ADDR_W  S-memory address.
- data  output  DATA_W  S-memory write data.
- wren  output  1  S-memory write enable.
- q  input  DATA_W  S-memory read data; valid one cycle after the address is presented.
- verify_error  output  1  sticky: a read-back mismatch was found in the current run.

Behaviour:
- Reset (reset_n=0 at a rising edge) forces, at that same edge:
  - state=IDLE;
  - finish=0, busy=0, wren=0, address=0, data=0, verify_error=0.
- Reset mid-run aborts the run immediately; no finish is produced. A write in flight at that edge still occurs, with no further writes after it.
- States: IDLE, WRITE, READ, DRAIN, DONE, HOLD.
- IDLE:
  - start=1 sampled → WRITE; counter=0; verify_error cleared; busy=1 from the next cycle.
- WRITE:
  - wren=1, address=counter, data=counter.
  - Exactly 2**ADDR_W consecutive write cycles, the first in the cycle after start is sampled.
  - On the last write (counter all-ones), counter wraps to 0.
  - Next state: READ if VERIFY=1, otherwise DONE.
- READ:
  - wren=0, address=counter, for 2**ADDR_W cycles.
  - Each cycle except the first compares q with (counter-1) mod 2**ADDR_W, resized to DATA_W.
  - A mismatch sets verify_error=1; it stays set until the next start is accepted.
- DRAIN: one cycle; compares q for the last address, then → DONE.
- DONE:
  - finish=1 and busy=1 for exactly one cycle, wren=0.
  - → HOLD if start=1 in this cycle, else → IDLE.
- HOLD: waits for start=0, then → IDLE. A start level held high never retriggers a second run.
- start asserted in any state other than IDLE is ignored.
- Latency from start sampled in IDLE to finish high:
  - VERIFY=0: 2**ADDR_W+1 cycles (257 at default).
  - VERIFY=1: 2*2**ADDR_W+2 cycles (514 at default).
- wren is never high outside WRITE. address holds its last value while idle.

Decomposition:
- Shared package rc4_pkg:
  - state enum type for this FSM;
  - default S-memory constants (S_ADDR_W=8, S_DATA_W=8, S_DEPTH=256).
- One natural sub-module, init_addr_counter: ADDR_W-bit counter with synchronous clear, enable and a terminal-count (all-ones) flag.

Test Plan:
- Reset then a 1-cycle start pulse, VERIFY=0:
  - 256 writes, address=data=0..255 in order, wren high exactly 256 cycles;
  - finish high exactly once, 257 cycles after start;
  - busy high 257 cycles.
- VERIFY=1 with an ideal RAM model: finish 514 cycles after start; verify_error=0; wren low throughout the read pass.
- VERIFY=1, RAM model corrupts location 0x7F to 0x00 → verify_error=1 at finish and stays 1; next start clears it.
- start held high continuously through two run lengths → exactly one finish pulse. Drop start, pulse it again → second run completes normally.
- reset_n=0 for one cycle at write address 100 → all outputs 0 next cycle, no finish, FSM in IDLE; a fresh start then writes 0..255.
- start pulsed again at write address 50 → ignored; the address sequence continues uninterrupted to 255.
